// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns ball position/direction and scores, advances them once per
// frame_tick and steps IDLE/SERVE/PLAY/SCORE/OVER.
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SPEED   = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [8:0] paddle_l_y,
  input  logic [8:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_SCORE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [9:0]       X_CENTRE   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]       Y_CENTRE   = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]       X_LEFT_LIM = 10'(PADDLE_W + BALL_SPEED);
  localparam logic [9:0]       X_LEFT_HIT = 10'(PADDLE_W);
  localparam logic [9:0]       X_RIGHT_HIT = 10'(SCREEN_W - PADDLE_W - BALL_SIZE);
  localparam logic [8:0]       Y_MAX      = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]       SPD10      = 10'(BALL_SPEED);
  localparam logic [8:0]       SPD9       = 9'(BALL_SPEED);
  localparam logic [9:0]       SIZE10     = 10'(BALL_SIZE);
  localparam logic [9:0]       PAD_H10    = 10'(PADDLE_H);
  localparam logic [9:0]       SCR_H10    = 10'(SCREEN_H);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  state_e           state_q, state_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [8:0]       ball_y_q, ball_y_d;
  // Direction bits: dir_x 1 = moving right, dir_y 1 = moving down.
  logic             dir_x_q, dir_x_d;
  logic             dir_y_q, dir_y_d;
  logic [3:0]       score_l_q, score_l_d;
  logic [3:0]       score_r_q, score_r_d;
  logic [CNT_W-1:0] serve_cnt_q, serve_cnt_d;
  logic             scorer_left_q, scorer_left_d;

  logic [9:0] y10, pl10, pr10;
  logic       ovl_l, ovl_r;
  logic [8:0] y_step;
  logic       dir_y_step;
  logic [9:0] x_step;
  logic       dir_x_step;
  logic       miss_l, miss_r;
  logic [3:0] score_new;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  assign y10  = {1'b0, ball_y_q};
  assign pl10 = {1'b0, paddle_l_y};
  assign pr10 = {1'b0, paddle_r_y};

  // Widened to 10 bits so paddle_y + PADDLE_H near the bottom cannot wrap.
  assign ovl_l = (y10 + SIZE10 > pl10) && (y10 < pl10 + PAD_H10);
  assign ovl_r = (y10 + SIZE10 > pr10) && (y10 < pr10 + PAD_H10);

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    y_step     = ball_y_q;
    dir_y_step = dir_y_q;
    if (!dir_y_q) begin
      if (ball_y_q < SPD9) begin
        y_step     = '0;
        dir_y_step = 1'b1;
      end else begin
        y_step = ball_y_q - SPD9;
      end
    end else begin
      if (y10 + SIZE10 + SPD10 > SCR_H10) begin
        y_step     = Y_MAX;
        dir_y_step = 1'b0;
      end else begin
        y_step = ball_y_q + SPD9;
      end
    end
  end

  always_comb begin
    x_step     = ball_x_q;
    dir_x_step = dir_x_q;
    miss_l     = 1'b0;
    miss_r     = 1'b0;
    if (!dir_x_q) begin
      if (ball_x_q < X_LEFT_LIM) begin
        if (ovl_l) begin
          x_step     = X_LEFT_HIT;
          dir_x_step = 1'b1;
        end else begin
          miss_l = 1'b1;
        end
      end else begin
        x_step = ball_x_q - SPD10;
      end
    end else begin
      if (ball_x_q + SPD10 > X_RIGHT_HIT) begin
        if (ovl_r) begin
          x_step     = X_RIGHT_HIT;
          dir_x_step = 1'b0;
        end else begin
          miss_r = 1'b1;
        end
      end else begin
        x_step = ball_x_q + SPD10;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    serve_cnt_d   = serve_cnt_q;
    scorer_left_d = scorer_left_q;
    score_new     = '0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d     = ST_SERVE;
          serve_cnt_d = '0;
          score_l_d   = '0;
          score_r_d   = '0;
          dir_x_d     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          ball_y_d = y_step;
          dir_y_d  = dir_y_step;
          ball_x_d = x_step;
          dir_x_d  = dir_x_step;
          if (miss_l || miss_r) begin
            state_d       = ST_SCORE;
            scorer_left_d = miss_r;
          end
        end
      end
      ST_SCORE: begin
        score_new = scorer_left_q ? sat_inc(score_l_q) : sat_inc(score_r_q);
        if (scorer_left_q) score_l_d = score_new;
        else               score_r_d = score_new;
        ball_x_d    = X_CENTRE;
        ball_y_d    = Y_CENTRE;
        serve_cnt_d = '0;
        // Next serve heads toward the player who conceded.
        dir_x_d     = scorer_left_q;
        state_d     = (score_new == WIN) ? ST_OVER : ST_SERVE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ball_x_q      <= X_CENTRE;
      ball_y_q      <= Y_CENTRE;
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      score_l_q     <= '0;
      score_r_q     <= '0;
      serve_cnt_q   <= '0;
      scorer_left_q <= 1'b0;
    end else if (ena) begin
      state_q       <= state_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_cnt_q   <= serve_cnt_d;
      scorer_left_q <= scorer_left_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);

endmodule
